// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ha.sv
// Half-adder cell: one-bit sum and carry of two inputs.
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_fa_bit.sv
// One full-adder bit composed of two half-adder cells and an OR of their carries.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    ha u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    ha u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder bit per cycle, LSB first, valid/ready in and out.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting a - b.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_s;
    logic               fa_c;
    logic [WIDTH-1:0]   b_load;
    logic               carry_load;

    fa_bit u_fa_bit (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // Subtraction is a + ~b + 1; cin is ignored in that mode.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so the LSB-first stream lands in place.
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    carry <= fa_c;
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        cout  <= fa_c;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode directly from the state register.
    assign in_ready  = (state == IDLE);
    assign busy      = (state == SHIFT);
    assign out_valid = (state == DONE);

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder that consumes the existing half-adder cell.
- Two half adders plus an OR gate form one full-adder bit; a carry flip-flop feeds it, and shift registers present one bit per cycle, LSB first.
- Accepts WIDTH-bit operands over a valid/ready handshake and returns sum plus carry-out after WIDTH cycles.
- Serves as the area-cheap adder for the Adders library and as the downstream consumer of the half-adder cell.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry-out.
- busy  output  1  high while in SHIFT.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, shift registers, sum, cout, carry and counter are all 0, out_valid=0, busy=0, and in_ready=1 (state-decoded). Handshakes are ignored until the first edge after rst_n rises.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: latch a and b into shift registers, set carry=cin, set cnt=0, go to SHIFT.
  - in_valid without acceptance has no effect.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge: the full-adder bit takes a_sh[0], b_sh[0] and carry. Its sum bit shifts into the MSB of the sum register (right shift), carry takes the bit's carry-out, a_sh and b_sh shift right, cnt increments.
  - At the edge where cnt==WIDTH-1: go to DONE and latch cout=final carry.
- DONE:
  - out_valid=1. sum and cout are held stable. in_ready=0; new in_valid is ignored.
  - On out_valid & out_ready: go to IDLE.
  - No accept-in-same-cycle overlap; the next operand can be accepted one cycle after the drain at the earliest.
- Latency: accept at edge k means out_valid=1 in the cycle after edge k+WIDTH. Throughput is one result per WIDTH+2 cycles at best.
- Arithmetic: sum = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of the true sum.
  - Example: all-ones + all-ones + 1 gives sum=all-ones, cout=1.
- Reset asserted mid-SHIFT or mid-DONE: the result is discarded immediately (asynchronously) and the block returns to IDLE with reset values.
- out_ready held high before DONE has no effect.
- in_valid may be deasserted after acceptance with no effect on the result.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled at acceptance.
  - sub=1: B is inverted on load and the carry-in is forced to 1 (cin ignored), so sum = a-b mod 2^WIDTH and cout=1 means no borrow.
  - sub=0: plain addition.
- Undefined: port sub is absent; addition only.

Decomposition:
- Package serial_adder_pkg:
  - state typedef (IDLE, SHIFT, DONE; 2-bit encoding).
  - Default WIDTH constant.
- Sub-module fa_bit: full adder built from two instances of the existing ha cell plus an OR on the two carries. It is instantiated once in serial_adder.

Test Plan:
- Basic add with exact latency: WIDTH=8, a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0; out_valid first high exactly 8 cycles after the accept edge; busy high for 8 cycles.
- Wrap-around: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- Wrap-around with carry-in: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises -> sum and cout held, in_ready=0, a concurrent in_valid with a=0x33 is not accepted. Raising out_ready drains the result; the next IDLE cycle accepts 0x33.
- Reset mid-operation: rst_n pulsed low at the 3rd SHIFT cycle -> out_valid=0, sum=0, in_ready=1 asynchronously; the next operation (0x10+0x20) gives 0x30.
- Subtraction (SERIAL_ADDER_SUB_EN defined): sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0; a=0x07, b=0x05 -> sum=0x02, cout=1.
